// File: rtl/ram_ctrl.sv
// ram_ctrl: sequences CPU byte requests into strobed RAM read/write cycles.
// Optional 16-bit (two byte-cycle) access is compiled in with RAM_CTRL_WORD_EN.
module ram_ctrl #(
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_word,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_doe,
    input  logic [7:0]        ram_din,
    output logic              ram_r,
    output logic              ram_w
);
    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic              op_we;
    logic              op_hi;
    logic              more_bytes;
    logic              accept;
    logic              last_strobe;
    logic [ADDR_W-1:0] op_addr;
    logic [15:0]       op_wdata;
    logic [7:0]        rd_lo;
    logic [15:0]       rd_word;

    logic              req_ready_d;
    logic              rsp_valid_d;
    logic [15:0]       rsp_rdata_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [7:0]        ram_dout_d;
    logic              ram_doe_d;
    logic              ram_r_d;
    logic              ram_w_d;

    assign accept      = req_valid & req_ready;
    assign last_strobe = (state == STROBE) && (cnt == '0);

`ifdef RAM_CTRL_WORD_EN
    logic       op_word;
    logic [7:0] rd_hi;

    // Second-byte tracking for 16-bit accesses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_word <= 1'b0;
            op_hi   <= 1'b0;
            rd_hi   <= '0;
        end else begin
            if (accept) begin
                op_word <= req_word;
                op_hi   <= 1'b0;
            end else if ((state == HOLD) && more_bytes) begin
                op_hi <= 1'b1;
            end
            if (last_strobe && !op_we && op_hi) begin
                rd_hi <= ram_din;
            end
        end
    end

    assign more_bytes = op_word & ~op_hi;
    assign rd_word    = op_word ? {rd_hi, rd_lo} : {8'h00, rd_lo};
`else
    logic unused_req_word;

    assign unused_req_word = req_word;
    assign op_hi           = 1'b0;
    assign more_bytes      = 1'b0;
    assign rd_word         = {8'h00, rd_lo};
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (cnt == '0) state_nxt = HOLD;
            HOLD:    state_nxt = more_bytes ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, strobe-width counter and read-byte capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_we    <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            rd_lo    <= '0;
            cnt      <= '0;
        end else begin
            if (accept) begin
                op_we    <= req_we;
                op_addr  <= req_addr;
                op_wdata <= req_wdata;
            end
            if (state == SETUP) begin
                cnt <= CNT_LOAD;
            end else if ((state == STROBE) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (last_strobe && !op_we && !op_hi) begin
                rd_lo <= ram_din;
            end
        end
    end

    // Output next-values; the bus is loaded one cycle ahead of the strobe
    always_comb begin
        req_ready_d = (state_nxt == IDLE);
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        ram_addr_d  = ram_addr;
        ram_dout_d  = ram_dout;
        ram_doe_d   = ram_doe;
        ram_r_d     = 1'b0;
        ram_w_d     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    ram_addr_d = req_addr;
                    ram_doe_d  = req_we;
                    if (req_we) ram_dout_d = req_wdata[7:0];
                end
            end
            SETUP: begin
                ram_r_d = ~op_we;
                ram_w_d = op_we;
            end
            STROBE: begin
                if (cnt != '0) begin
                    ram_r_d = ~op_we;
                    ram_w_d = op_we;
                end
            end
            HOLD: begin
                if (more_bytes) begin
                    ram_addr_d = op_addr + ADDR_W'(1);
                    ram_doe_d  = op_we;
                    if (op_we) ram_dout_d = op_wdata[15:8];
                end else begin
                    ram_doe_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (!op_we) rsp_rdata_d = rd_word;
                end
            end
            default: begin
                ram_doe_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_addr  <= '0;
            ram_dout  <= '0;
            ram_doe   <= 1'b0;
            ram_r     <= 1'b0;
            ram_w     <= 1'b0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            ram_addr  <= ram_addr_d;
            ram_dout  <= ram_dout_d;
            ram_doe   <= ram_doe_d;
            ram_r     <= ram_r_d;
            ram_w     <= ram_w_d;
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: instance 0 runs WAIT_CYCLES=0, instance 1 WAIT_CYCLES=3.
module tb_ram_ctrl;
    localparam int unsigned ADDR_W = 15;

    typedef struct {
        logic [15:0] rdata;
        int          due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid [2];
    logic              req_ready [2];
    logic              req_we    [2];
    logic              req_word  [2];
    logic [ADDR_W-1:0] req_addr  [2];
    logic [15:0]       req_wdata [2];
    logic              rsp_valid [2];
    logic [15:0]       rsp_rdata [2];
    logic [ADDR_W-1:0] ram_addr  [2];
    logic [7:0]        ram_dout  [2];
    logic              ram_doe   [2];
    logic [7:0]        ram_din   [2];
    logic              ram_r     [2];
    logic              ram_w     [2];

    logic [7:0] mem0 [0:(1<<ADDR_W)-1];
    logic [7:0] mem1 [0:(1<<ADDR_W)-1];

    exp_t q [2][$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic              prev_strobe [2];
    int                slen        [2];
    logic [ADDR_W-1:0] prev_addr   [2];
    logic [7:0]        prev_dout   [2];
    exp_t              e;

    ram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_word(req_word[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .ram_addr(ram_addr[0]), .ram_dout(ram_dout[0]), .ram_doe(ram_doe[0]),
        .ram_din(ram_din[0]), .ram_r(ram_r[0]), .ram_w(ram_w[0])
    );

    ram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_word(req_word[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .ram_addr(ram_addr[1]), .ram_dout(ram_dout[1]), .ram_doe(ram_doe[1]),
        .ram_din(ram_din[1]), .ram_r(ram_r[1]), .ram_w(ram_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAMs
    assign ram_din[0] = mem0[ram_addr[0]];
    assign ram_din[1] = mem1[ram_addr[1]];
    always @(posedge clk) begin
        if (ram_w[0]) mem0[ram_addr[0]] <= ram_dout[0];
        if (ram_w[1]) mem1[ram_addr[1]] <= ram_dout[1];
    end

    function automatic int wait_of(input int inst);
        return (inst == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h required %0h", name, inst, got, exp);
        end
    endtask

    // Monitor: bus invariants plus scoreboard pop on every response pulse
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                prev_strobe[i] <= 1'b0;
                slen[i]        <= 0;
            end else begin
                check("rw_exclusive", i, 32'(ram_r[i] & ram_w[i]), 32'd0);
                check("read_doe_low", i, 32'(ram_r[i] & ram_doe[i]), 32'd0);
                if (ram_r[i] || ram_w[i] || prev_strobe[i]) begin
                    check("addr_stable", i, 32'(ram_addr[i]), 32'(prev_addr[i]));
                    check("dout_stable", i, 32'(ram_dout[i]), 32'(prev_dout[i]));
                end
                if (prev_strobe[i] && !(ram_r[i] || ram_w[i]))
                    check("strobe_len", i, 32'(slen[i]), 32'(wait_of(i) + 1));
                if (rsp_valid[i]) begin
                    check("ready_at_rsp", i, 32'(req_ready[i]), 32'd1);
                    if (q[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp[%0d]: got rsp_valid=1 required none pending", i);
                    end else begin
                        e = q[i].pop_front();
                        check("rsp_rdata", i, 32'(rsp_rdata[i]), 32'(e.rdata));
                        check("rsp_cycle", i, 32'(cyc + 1), 32'(e.due));
                    end
                end
                prev_strobe[i] <= ram_r[i] | ram_w[i];
                slen[i]        <= (ram_r[i] | ram_w[i]) ? slen[i] + 1 : 0;
            end
            prev_addr[i] <= ram_addr[i];
            prev_dout[i] <= ram_dout[i];
        end
    end

    // Present a request, wait for its accept edge and record the expected response
    task automatic issue(input int inst, input logic we, input logic word,
                         input logic [ADDR_W-1:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rdata, input int lat, input bit want,
                         output int acc);
        int n = 0;
        @(negedge clk);
        req_valid[inst] = 1'b1;
        req_we[inst]    = we;
        req_word[inst]  = word;
        req_addr[inst]  = addr;
        req_wdata[inst] = wdata;
        while (!req_ready[inst] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[inst]) begin
            total++;
            bad++;
            $display("FAIL accept_timeout[%0d]: got req_ready=0 required 1", inst);
        end
        acc = cyc + 1;
        if (want) q[inst].push_back('{exp_rdata, acc + lat});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int inst);
        @(negedge clk);
        req_valid[inst] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q[0].size() + q[1].size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 0, 32'(q[0].size() + q[1].size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, pacc, n, hits_top, hits_zero;
        logic [15:0] wr_vals [3];
        wr_vals[0] = 16'h0011;
        wr_vals[1] = 16'h0022;
        wr_vals[2] = 16'h0033;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_word[i]  = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
            check("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
            check("rst_rsp_rdata", i, 32'(rsp_rdata[i]), 32'd0);
            check("rst_ram_addr",  i, 32'(ram_addr[i]),  32'd0);
            check("rst_ram_dout",  i, 32'(ram_dout[i]),  32'd0);
            check("rst_ram_ctl",   i, 32'({ram_doe[i], ram_r[i], ram_w[i]}), 32'd0);
        end
        #2 rst = 1'b0;

        // Write then read back, WAIT_CYCLES=0
        issue(0, 1'b1, 1'b0, 15'h0012, 16'h005A, 16'h0000, 4, 1'b1, acc);
        issue(0, 1'b0, 1'b0, 15'h0012, 16'h0000, 16'h005A, 4, 1'b1, acc);
        pacc = acc;

        // Back-to-back writes with req_valid held, then reads back
        for (int k = 0; k < 3; k++) begin
            issue(0, 1'b1, 1'b0, 15'(k + 1), wr_vals[k], 16'h005A, 4, 1'b1, acc);
            check("accept_gap", 0, 32'(acc - pacc), 32'd4);
            pacc = acc;
        end
        for (int k = 0; k < 3; k++) begin
            issue(0, 1'b0, 1'b0, 15'(k + 1), 16'h0000, wr_vals[k], 4, 1'b1, acc);
            check("accept_gap", 0, 32'(acc - pacc), 32'd4);
            pacc = acc;
        end
        idle(0);

        // WAIT_CYCLES=3 accesses, including the top address
        issue(1, 1'b1, 1'b0, 15'h7FFF, 16'h00C3, 16'h0000, 7, 1'b1, acc);
        issue(1, 1'b0, 1'b0, 15'h7FFF, 16'h0000, 16'h00C3, 7, 1'b1, acc);
        issue(1, 1'b1, 1'b0, 15'h0100, 16'h00A5, 16'h00C3, 7, 1'b1, acc);
        issue(1, 1'b0, 1'b0, 15'h0100, 16'h0000, 16'h00A5, 7, 1'b1, acc);
        idle(1);
        drain();

        // Reset during the strobe of a write: no response expected
        issue(0, 1'b1, 1'b0, 15'h0040, 16'h0099, 16'h0000, 4, 1'b0, acc);
        idle(0);
        n = 0;
        while (!ram_w[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("strobe_seen", 0, 32'(ram_w[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_drop_w",   0, 32'(ram_w[0]),   32'd0);
        check("rst_drop_doe", 0, 32'(ram_doe[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_ready", 0, 32'(req_ready[0]), 32'd1);
        check("post_rst_rdata", 0, 32'(rsp_rdata[0]), 32'd0);

        // Word read across the address wrap (byte read when the feature is off)
        issue(0, 1'b1, 1'b0, 15'h7FFF, 16'h0034, 16'h0000, 4, 1'b1, acc);
        issue(0, 1'b1, 1'b0, 15'h0000, 16'h0012, 16'h0000, 4, 1'b1, acc);
`ifdef RAM_CTRL_WORD_EN
        issue(0, 1'b0, 1'b1, 15'h7FFF, 16'h0000, 16'h1234, 7, 1'b1, acc);
`else
        issue(0, 1'b0, 1'b1, 15'h7FFF, 16'h0000, 16'h0034, 4, 1'b1, acc);
`endif
        idle(0);
        hits_top  = 0;
        hits_zero = 0;
        for (int k = 0; k < 10; k++) begin
            if (ram_r[0] && ram_addr[0] == 15'h7FFF) hits_top++;
            if (ram_r[0] && ram_addr[0] == 15'h0000) hits_zero++;
            @(negedge clk);
        end
        check("word_lo_strobes", 0, 32'(hits_top), 32'd1);
`ifdef RAM_CTRL_WORD_EN
        check("word_hi_strobes", 0, 32'(hits_zero), 32'd1);
`else
        check("word_hi_strobes", 0, 32'(hits_zero), 32'd0);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Sequences CPU-side byte read/write requests into strobed `r`/`w` cycles on the RAM's address/data bus.
- Guarantees address/data setup and hold around each strobe, with a programmable number of strobe wait cycles.
- Sits directly upstream of the RAM: the CPU core issues requests here, and this block alone drives the RAM's address, data and strobe lines.

Parameters:
- ADDR_W, 15: RAM address width (`ram_addr`, `req_addr`).
- WAIT_CYCLES, 0: extra cycles the strobe is held beyond the first; range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_word  input  1  16-bit access request (used only with RAM_CTRL_WORD_EN)
- req_addr  input  ADDR_W  byte address
- req_wdata  input  16  write data; [7:0] is the low byte
- rsp_valid  output  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  output  16  read data, valid while rsp_valid
- ram_addr  output  ADDR_W  RAM address bus
- ram_dout  output  8  data driven toward RAM
- ram_doe  output  1  data-bus output enable; external tristate uses it
- ram_din  input  8  data returned by RAM
- ram_r  output  1  RAM read strobe
- ram_w  output  1  RAM write strobe

Behaviour:
- Reset values (asynchronous, while rst=1):
  - state=IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_rdata=0.
  - ram_addr=0, ram_dout=0.
  - ram_doe=0, ram_r=0, ram_w=0.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- Request acceptance:
  - req_ready=1 only in IDLE.
  - Transfer occurs on a rising edge with req_valid & req_ready.
  - At acceptance, req_we, req_word, req_addr and req_wdata are registered; the request inputs are then ignored until the next IDLE.
- IDLE -> SETUP on accept.
- SETUP (1 cycle):
  - ram_addr valid.
  - For writes, ram_dout=byte and ram_doe=1.
  - Strobes low.
- STROBE (WAIT_CYCLES+1 cycles):
  - ram_r=1 (read) or ram_w=1 (write).
  - A 4-bit counter counts down; the controller exits when the counter reaches 0.
  - For reads, ram_din is captured on the last STROBE edge.
- HOLD (1 cycle):
  - Strobes low.
  - ram_addr, ram_dout and ram_doe unchanged.
- HOLD -> IDLE:
  - ram_doe clears on entry to IDLE.
  - rsp_valid=1 for exactly the first IDLE cycle.
  - rsp_rdata={8'h00, byte} for reads; for writes rsp_rdata keeps its previous value.
- Latency:
  - The accept edge is cycle 0; rsp_valid is high in cycle WAIT_CYCLES+4.
  - A new request can be accepted in that same cycle (back-to-back, no idle gap).
- Invariants:
  - ram_r & ram_w never both 1.
  - ram_doe=0 throughout any read.
  - ram_addr is stable from SETUP through HOLD.
  - Strobes never rise in the same cycle the address changes.
- Reset mid-operation:
  - Strobes and ram_doe drop immediately (asynchronous).
  - The in-flight request is discarded with no rsp_valid.
  - The RAM contents for an interrupted write are undefined.
- rsp_valid has no backpressure; the consumer must take it on the pulse.

Optional Feature:
- Macro: RAM_CTRL_WORD_EN.
- Defined:
  - A request with req_word=1 runs two full SETUP/STROBE/HOLD byte cycles: low byte at req_addr, then high byte at req_addr+1.
  - The address increment wraps modulo 2^ADDR_W, so the top address wraps to 0.
  - A single rsp_valid is issued after the second HOLD, with rsp_rdata={hi, lo}.
  - Latency is 2*(WAIT_CYCLES+3)+1.
  - req_word=0 behaves as the byte access above.
- Undefined:
  - req_word is ignored; every access is a byte access.
  - rsp_rdata[15:8] is always 0.

Test Plan:
1. WAIT_CYCLES=0: write addr 0x0012 data 0x5A, then read 0x0012 -> ram_w high exactly 1 cycle; read returns rsp_rdata=0x005A in cycle 4 after its accept.
2. WAIT_CYCLES=3: read addr 0x7FFF with ram_din=0xC3 -> ram_r high 4 cycles; rsp_valid in cycle 7; rsp_rdata=0x00C3; ram_doe stays 0.
3. req_valid held high for 3 writes (0x1->0x11, 0x2->0x22, 0x3->0x33) -> req_ready high in each rsp_valid cycle; accepts occur every 4 cycles; ram_r and ram_w never overlap.
4. Assert rst during the STROBE of a write -> ram_w and ram_doe drop in the same cycle; no rsp_valid; req_ready=1 after release.
5. RAM_CTRL_WORD_EN, word read at 0x7FFF with RAM holding 0x34 at 0x7FFF and 0x12 at 0x0000 -> second cycle addresses 0x0000; rsp_rdata=0x1234; one rsp_valid at cycle 7.
6. Check address/data stability: ram_addr and ram_dout unchanged from SETUP through HOLD on every access; ram_addr unchanged on the cycles where ram_r/ram_w rise.
